// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode constants, fetch FSM states and the
// instruction-shape predicates also used by the Fetch stage.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] IIADDQ  = 4'hC;

    localparam int unsigned MAX_IBYTES = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B0,
        ST_LEN,
        ST_REST,
        ST_RESP
    } fetch_state_e;

    // Instruction carries a register-specifier byte.
    function automatic logic need_regids(input logic [3:0] icode);
        return icode inside {IRRMOVQ, IOPQ, IPUSHQ, IPOPQ,
                             IIRMOVQ, IRMMOVQ, IMRMOVQ, IIADDQ};
    endfunction

    // Instruction carries an 8-byte constant word.
    function automatic logic need_valC(input logic [3:0] icode);
        return icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL, IIADDQ};
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Instruction length decoder: icode -> total byte count (1, 2, 9 or 10).
// Unknown icodes report length 1 so the byte is returned for downstream checks.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] length
);

    // Length = opcode byte + optional regid byte + optional 8-byte constant.
    always_comb begin
        length = 4'd1;
        if (need_regids(icode)) length = length + 4'd1;
        if (need_valC(icode))   length = length + 4'd8;
    end

endmodule

// File: rtl/y86_imem_fetcher.sv
// Byte-serial Y86-64 instruction fetcher: reads only the bytes the
// instruction needs from a byte-wide synchronous memory and returns the
// 80-bit little-endian window plus an out-of-range error flag.
module y86_imem_fetcher
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_BYTES = 64'd65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [63:0] req_pc,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [79:0] rsp_ibytes,
    output logic        rsp_imem_error,
    output logic        mem_rd,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata
);

    fetch_state_e r_state;
    fetch_state_e w_next;

    logic [63:0]                  r_pc;
    logic [MAX_IBYTES-1:0][7:0]   r_win;
    logic                         r_err;
    logic [3:0]                   r_idx;
    logic [3:0]                   r_len;

    logic [3:0]  w_len;
    logic [3:0]  w_rd_k;
    logic [64:0] w_sum;
    logic        w_oob;
    logic        w_more;

    y86_instr_len u_len (
        .icode  (mem_rdata[7:4]),
        .length (w_len)
    );

    // Offset of the byte that would be read this cycle: 0 in B0, otherwise
    // the byte after the one currently returning.
    assign w_rd_k = (r_state == ST_B0) ? 4'd0 : r_idx + 4'd1;
    // 65-bit sum so a carry out of 64 bits also counts as out of range.
    assign w_sum  = {1'b0, r_pc} + {61'd0, w_rd_k};
    assign w_oob  = (w_sum >= {1'b0, MEM_BYTES});
    assign w_more = ((r_idx + 4'd1) < r_len);

    assign rsp_ibytes     = r_win;
    assign rsp_imem_error = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake / memory strobe decode.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = ST_B0;
            end
            ST_B0: begin
                if (w_oob) begin
                    w_next = ST_RESP;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = w_sum[63:0];
                    w_next   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_len == 4'd1 || w_oob) begin
                    w_next = ST_RESP;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = w_sum[63:0];
                    w_next   = ST_REST;
                end
            end
            ST_REST: begin
                if (!w_more || w_oob) begin
                    w_next = ST_RESP;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = w_sum[63:0];
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: latch PC, collect returning bytes, record range errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= '0;
            r_win <= '0;
            r_err <= 1'b0;
            r_idx <= '0;
            r_len <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_pc  <= req_pc;
                        r_win <= '0;
                        r_err <= 1'b0;
                        r_idx <= '0;
                        r_len <= '0;
                    end
                end
                ST_B0: begin
                    if (w_oob) begin
                        r_err <= 1'b1;
                        r_win <= '0;
                    end
                end
                ST_LEN: begin
                    r_win[0] <= mem_rdata;
                    r_len    <= w_len;
                    if (w_len != 4'd1) begin
                        // Later assignment to the whole window overrides byte 0.
                        if (w_oob) begin
                            r_err <= 1'b1;
                            r_win <= '0;
                        end else begin
                            r_idx <= 4'd1;
                        end
                    end
                end
                ST_REST: begin
                    r_win[r_idx] <= mem_rdata;
                    if (w_more) begin
                        if (w_oob) begin
                            r_err <= 1'b1;
                            r_win <= '0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_imem_fetcher.sv
// Self-checking bench for y86_imem_fetcher: directed cases from the test plan
// plus randomized requests against a behavioural fetch model.
module tb_y86_imem_fetcher;

    localparam logic [63:0] MEMB = 64'd65536;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_pc = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [79:0] rsp_ibytes;
    logic        rsp_imem_error;
    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    y86_imem_fetcher #(.MEM_BYTES(MEMB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_ibytes     (rsp_ibytes),
        .rsp_imem_error (rsp_imem_error),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] tmem [0:65535];
    int checks = 0;
    int errors = 0;

    // Instruction length indexed by icode.
    int LEN_TAB [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 10, 1, 1, 1};

    function automatic void chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Behavioural fetch result for a request at pc.
    function automatic void model(input logic [63:0] pc, output logic e, output logic [79:0] ib,
                                  output int c, output int nr);
        int n;
        logic [64:0] a;
        e = 1'b0; ib = '0; c = 0; nr = 0;
        a = {1'b0, pc};
        if (a >= {1'b0, MEMB}) begin
            e = 1'b1; c = 2; return;
        end
        n = LEN_TAB[tmem[pc[15:0]][7:4]];
        for (int k = 1; k < n; k++) begin
            a = {1'b0, pc} + 65'(k);
            if (a >= {1'b0, MEMB}) begin
                e = 1'b1; c = k + 2; nr = k; return;
            end
        end
        for (int k = 0; k < n; k++) ib[8*k +: 8] = tmem[16'(pc[15:0] + 16'(k))];
        c = n + 2;
        nr = n;
    endfunction

    // Synchronous byte memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= tmem[mem_addr[15:0]];
        else        mem_rdata <= 8'($urandom);
    end

    bit          active = 0, got_rsp = 0, want_rdy = 0;
    int          cyc = 0, nrd = 0;
    logic [63:0] exp_pc;
    logic        exp_err;
    logic [79:0] exp_ib;
    int          exp_cyc = 0, exp_nrd = 0;
    logic        last_err;
    logic [79:0] last_ib;
    int          last_cyc = 0, last_nrd = 0;

    // Compare process: checks every cycle mid-period against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0; got_rsp = 0; want_rdy = 0;
            chk("reset_ctrl", {req_ready, rsp_valid, rsp_imem_error, mem_rd}, 4'b1000);
            chk("reset_addr", mem_addr, 0);
            chk("reset_ibytes", rsp_ibytes, 0);
        end else begin
            if (!mem_rd) chk("mem_addr_zero", mem_addr, 0);
            else         chk("mem_rd_in_range", mem_addr < MEMB, 1);
            if (want_rdy) begin
                chk("req_ready_after_rsp", req_ready, 1);
                want_rdy = 0;
            end
            if (active) begin
                cyc++;
                if (mem_rd) begin
                    if (nrd < exp_nrd) begin
                        chk("rd_cycle", cyc, nrd + 1);
                        chk("rd_addr", mem_addr, exp_pc + 64'(nrd));
                    end else begin
                        chk("extra_rd", mem_rd, 0);
                    end
                    nrd++;
                end
                if (rsp_valid && !got_rsp) begin
                    got_rsp = 1;
                    chk("rsp_cycle", cyc, exp_cyc);
                    chk("rsp_ibytes", rsp_ibytes, exp_ib);
                    chk("rsp_err", rsp_imem_error, exp_err);
                    chk("rd_count", nrd, exp_nrd);
                    last_ib = rsp_ibytes; last_err = rsp_imem_error;
                    last_cyc = cyc; last_nrd = nrd;
                end else if (rsp_valid) begin
                    chk("hold_ibytes", rsp_ibytes, last_ib);
                    chk("hold_err", rsp_imem_error, last_err);
                end else if (cyc == exp_cyc) begin
                    chk("rsp_valid_timing", rsp_valid, 1);
                end
                if (rsp_valid && rsp_ready) begin
                    active = 0;
                    want_rdy = 1;
                end
            end else begin
                chk("idle_quiet", {rsp_valid, mem_rd}, 0);
                if (req_valid && req_ready) begin
                    active = 1; got_rsp = 0; cyc = 0; nrd = 0;
                    exp_pc = req_pc;
                    model(req_pc, exp_err, exp_ib, exp_cyc, exp_nrd);
                end
            end
        end
    end

    // One request/response transaction; hold = cycles of rsp_ready low after rsp_valid.
    task automatic do_req(input logic [63:0] pc, input int hold);
        int t;
        chk("req_ready_pre", req_ready, 1);
        req_valid = 1'b1;
        req_pc    = pc;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_pc    = '0;
        t = 0;
        while (!rsp_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", rsp_valid, 1);
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] pc;
        int sel;
        for (int i = 0; i < 65536; i++) tmem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_rd", mem_rd, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // halt
        tmem[0] = 8'h00;
        do_req(64'h0, 0);
        chk("halt_ib", last_ib, 80'h0);
        chk("halt_err", last_err, 0);
        chk("halt_cyc", last_cyc, 3);
        chk("halt_nrd", last_nrd, 1);

        // pushq
        tmem[16'h10] = 8'hA0; tmem[16'h11] = 8'h2F;
        do_req(64'h10, 0);
        chk("push_ib", last_ib, 80'h2FA0);
        chk("push_cyc", last_cyc, 4);
        chk("push_nrd", last_nrd, 2);

        // irmovq $0x0123456789ABCDEF,%rdx
        tmem[16'h100] = 8'h30; tmem[16'h101] = 8'hF2; tmem[16'h102] = 8'hEF;
        tmem[16'h103] = 8'hCD; tmem[16'h104] = 8'hAB; tmem[16'h105] = 8'h89;
        tmem[16'h106] = 8'h67; tmem[16'h107] = 8'h45; tmem[16'h108] = 8'h23;
        tmem[16'h109] = 8'h01;
        do_req(64'h100, 1);
        chk("irmov_ib", last_ib, 80'h0123456789ABCDEF_F2_30);
        chk("irmov_cyc", last_cyc, 12);
        chk("irmov_nrd", last_nrd, 10);

        // jmp straddling the end of memory
        tmem[16'hFFFD] = 8'h70;
        do_req(MEMB - 64'd3, 0);
        chk("oob_err", last_err, 1);
        chk("oob_ib", last_ib, 80'h0);
        chk("oob_cyc", last_cyc, 5);
        chk("oob_nrd", last_nrd, 3);

        // wrap at top of address space
        do_req(64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("wrap_err", last_err, 1);
        chk("wrap_cyc", last_cyc, 2);
        chk("wrap_nrd", last_nrd, 0);

        // backpressure on an OPq
        tmem[16'h200] = 8'h60; tmem[16'h201] = 8'h01;
        do_req(64'h200, 5);
        chk("bp_ib", last_ib, 80'h0160);
        chk("bp_cyc", last_cyc, 4);

        // mrmovq interrupted by reset after byte 3
        tmem[16'h300] = 8'h50;
        chk("req_ready_pre_rst", req_ready, 1);
        req_valid = 1'b1; req_pc = 64'h300; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_pc = '0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("mid_rd_active", mem_rd, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {req_ready, rsp_valid, rsp_imem_error, mem_rd}, 4'b1000);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_ibytes", rsp_ibytes, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);

        // randomized requests
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel < 2)       pc = 64'($urandom_range(0, 65535));
            else if (sel == 2) pc = 64'(65536 - $urandom_range(1, 11));
            else               pc = {32'($urandom), 32'($urandom)} | 64'h1_0000;
            if (pc < MEMB) tmem[pc[15:0]] = {4'($urandom_range(0, 15)), 4'($urandom)};
            do_req(pc, int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
